dev_dma_blockmover: RTL and testbench

Parametrised DCPU16 hardware device that moves memory blocks over the shared DMA bus ("Eastbridge") on CPU command ("Westbridge").
- Supports block copy (read then write per word) and block fill (write only).
- Optionally raises a completion interrupt.
- Sits beside the other devices on the DMA arbiter: one DMA_want/DMA_access pair, one HWI command port.

---
 rtl/dev_dma_blockmover_if.sv | 23 ++
 rtl/dev_dma_blockmover.sv | 156 +++++++++++++++
 tb/tb_dev_dma_blockmover.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dev_dma_blockmover_if.sv
// Eastbridge DMA bus bundle between one device (master) and the arbiter/memory side (slave).
// Read data returns READ_LAT cycles after a granted read; no backpressure beyond the grant.
interface dev_dma_blockmover_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              DMA_want;
  logic              DMA_access;
  logic [ADDR_W-1:0] DMA_addr;
  logic [DATA_W-1:0] DMA_out;
  logic              DMA_wren;
  logic [DATA_W-1:0] DMA_data;

  modport master (
    output DMA_want, DMA_addr, DMA_out, DMA_wren,
    input  DMA_access, DMA_data
  );

  modport slave (
    input  DMA_want, DMA_addr, DMA_out, DMA_wren,
    output DMA_access, DMA_data
  );
endinterface

// File: rtl/dev_dma_blockmover.sv
// DCPU16 block copy/fill engine on the shared DMA bus; one word per granted write,
// copy costs READ_LAT+2 cycles per word minimum; stalls indefinitely while the grant is withheld.
module dev_dma_blockmover #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int COUNT_W  = 16,
  parameter int READ_LAT = 1
) (
  input  logic               DMA_CLOCK,
  input  logic               DMA_RESET_n,
  input  logic               HWI_strobe,
  input  logic [DATA_W-1:0]  HWI_A,
  input  logic [DATA_W-1:0]  HWI_B,
  input  logic [COUNT_W-1:0] HWI_C,
  input  logic [ADDR_W-1:0]  HWI_X,
  output logic [COUNT_W-1:0] HWI_C_out,
  output logic               HWI_C_wren,
  output logic               IRQ_request,
  output logic [DATA_W-1:0]  IRQ_msg,
  output logic               busy,
  dev_dma_blockmover_if.master dma
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [DATA_W-1:0] OP_STATUS = DATA_W'(0);
  localparam logic [DATA_W-1:0] OP_COPY   = DATA_W'(1);
  localparam logic [DATA_W-1:0] OP_FILL   = DATA_W'(2);
  localparam logic [DATA_W-1:0] OP_SETIRQ = DATA_W'(3);

  localparam int LAT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               copy_q, copy_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0]  msg_q, msg_d;
  logic [COUNT_W-1:0] c_out_q, c_out_d;
  logic               c_wren_q, c_wren_d;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    data_d   = data_q;
    copy_d   = copy_q;
    lat_d    = lat_q;
    msg_d    = msg_q;
    c_out_d  = c_out_q;
    c_wren_d = 1'b0;

    // len_q already reads 0 in DONE, so a coincident STATUS sees the finished count
    if (HWI_strobe && HWI_A == OP_STATUS) begin
      c_wren_d = 1'b1;
      c_out_d  = len_q;
    end
    if (HWI_strobe && HWI_A == OP_SETIRQ) begin
      msg_d = HWI_B;
    end

    case (state_q)
      S_IDLE: begin
        if (HWI_strobe && (HWI_A == OP_COPY || HWI_A == OP_FILL)) begin
          copy_d = (HWI_A == OP_COPY);
          src_d  = ADDR_W'(HWI_B);
          dst_d  = HWI_X;
          len_d  = HWI_C;
          data_d = HWI_B;
          if (HWI_C == '0) begin
            state_d = S_DONE;
          end else if (HWI_A == OP_COPY) begin
            state_d = S_RD_REQ;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (dma.DMA_access) begin
          state_d = S_RD_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(READ_LAT)) begin
          data_d  = dma.DMA_data;
          state_d = S_WR_REQ;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        if (dma.DMA_access) begin
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          len_d = len_q - 1'b1;
          if (len_q == COUNT_W'(1)) begin
            state_d = S_DONE;
          end else if (copy_q) begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge DMA_CLOCK) begin
    if (!DMA_RESET_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      copy_q   <= 1'b0;
      lat_q    <= '0;
      msg_q    <= '0;
      c_out_q  <= '0;
      c_wren_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      data_q   <= data_d;
      copy_q   <= copy_d;
      lat_q    <= lat_d;
      msg_q    <= msg_d;
      c_out_q  <= c_out_d;
      c_wren_q <= c_wren_d;
    end
  end

  // Bus outputs decode straight from registered state, so they stay stable while a grant is pending
  assign dma.DMA_want = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign dma.DMA_wren = (state_q == S_WR_REQ);
  assign dma.DMA_addr = (state_q == S_WR_REQ) ? dst_q :
                        (state_q == S_RD_REQ) ? src_q : '0;
  assign dma.DMA_out  = (state_q == S_WR_REQ) ? data_q : '0;

  assign busy        = (state_q != S_IDLE);
  assign IRQ_request = (state_q == S_DONE) && (msg_q != '0);
  assign IRQ_msg     = msg_q;
  assign HWI_C_out   = c_out_q;
  assign HWI_C_wren  = c_wren_q;

endmodule

// File: tb/tb_dev_dma_blockmover.sv
// Directed bench for dev_dma_blockmover with a behavioural memory/arbiter on the DMA bus.
module tb_dev_dma_blockmover;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [15:0] hwi_a, hwi_b, hwi_c, hwi_x;
  logic [15:0] c_out;
  logic        c_wren, irq_req, busy;
  logic [15:0] irq_msg;

  always #5 clk = ~clk;

  dev_dma_blockmover_if #(.ADDR_W(16), .DATA_W(16)) dma_bus ();

  dev_dma_blockmover #(
    .DATA_W(16), .ADDR_W(16), .COUNT_W(16), .READ_LAT(RL)
  ) dut (
    .DMA_CLOCK  (clk),
    .DMA_RESET_n(rst_n),
    .HWI_strobe (strobe),
    .HWI_A      (hwi_a),
    .HWI_B      (hwi_b),
    .HWI_C      (hwi_c),
    .HWI_X      (hwi_x),
    .HWI_C_out  (c_out),
    .HWI_C_wren (c_wren),
    .IRQ_request(irq_req),
    .IRQ_msg    (irq_msg),
    .busy       (busy),
    .dma        (dma_bus.master)
  );

  int          cyc = 0, wr_n = 0, rd_n = 0, want_n = 0, busy_n = 0, irq_n = 0;
  logic [15:0] irq_last = '0;
  logic [15:0] wr_addr[$], wr_dat[$];
  int          wr_cyc[$];
  logic [15:0] mem[int];
  bit          rp_v[RL];
  logic [15:0] rp_a[RL];
  int          acc_mode = 0;
  logic        rnd_bit = 1'b0;
  int          errors = 0, checks = 0;

  // Unwritten locations read back as a fixed address-derived pattern
  function automatic logic [15:0] mem_rd(input logic [15:0] ad);
    if (mem.exists(int'(ad))) return mem[int'(ad)];
    return ad ^ 16'h5A3C;
  endfunction

  assign dma_bus.DMA_access = (acc_mode == 1) || (acc_mode == 2 && rnd_bit);

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  always @(posedge clk) begin
    if (dma_bus.DMA_want) want_n++;
    if (busy) busy_n++;
    if (irq_req) begin
      irq_n++;
      irq_last = irq_msg;
    end
    if (dma_bus.DMA_want && dma_bus.DMA_access && dma_bus.DMA_wren) begin
      mem[int'(dma_bus.DMA_addr)] = dma_bus.DMA_out;
      wr_addr.push_back(dma_bus.DMA_addr);
      wr_dat.push_back(dma_bus.DMA_out);
      wr_cyc.push_back(cyc);
      wr_n++;
    end
    if (dma_bus.DMA_want && dma_bus.DMA_access && !dma_bus.DMA_wren) rd_n++;
    for (int i = RL - 1; i > 0; i--) begin
      rp_v[i] = rp_v[i-1];
      rp_a[i] = rp_a[i-1];
    end
    rp_v[0] = dma_bus.DMA_want && dma_bus.DMA_access && !dma_bus.DMA_wren;
    rp_a[0] = dma_bus.DMA_addr;
    dma_bus.DMA_data <= rp_v[RL-1] ? mem_rd(rp_a[RL-1]) : 16'hDEAD;
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hwi(input logic [15:0] op, input logic [15:0] bb, input logic [15:0] cc,
                     input logic [15:0] xx, output int scyc);
    @(negedge clk);
    strobe = 1'b1;
    hwi_a  = op;
    hwi_b  = bb;
    hwi_c  = cc;
    hwi_x  = xx;
    scyc   = cyc;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fcyc);
    fcyc = -1;
    for (int i = 0; i < budget && fcyc < 0; i++) begin
      @(negedge clk);
      if (!busy) fcyc = cyc;
    end
    if (fcyc < 0) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget && wr_n < target; i++) @(negedge clk);
    if (wr_n < target) check_eq("write_timeout", 32'(wr_n), 32'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, wbase, bbase, ibase, s, f;
    logic [15:0] exp_src[3];
    rst_n  = 1'b0;
    strobe = 1'b0;
    hwi_a  = '0;
    hwi_b  = '0;
    hwi_c  = '0;
    hwi_x  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_want", 32'(dma_bus.DMA_want), 32'd0);
    check_eq("rst_wren", 32'(dma_bus.DMA_wren), 32'd0);
    check_eq("rst_irq", 32'(irq_req), 32'd0);
    check_eq("rst_irqmsg", 32'(irq_msg), 32'd0);
    check_eq("rst_cwren", 32'(c_wren), 32'd0);

    // FILL with the grant tied high: one write per cycle
    acc_mode = 1;
    base  = wr_n;
    ibase = irq_n;
    hwi(16'd2, 16'hBEEF, 16'd4, 16'h0100, s);
    wait_idle(50, f);
    check_eq("fill_count", 32'(wr_n - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fill_addr%0d", i), 32'(wr_addr[base+i]), 32'h0100 + 32'(i));
      check_eq($sformatf("fill_dat%0d", i), 32'(wr_dat[base+i]), 32'hBEEF);
      check_eq($sformatf("fill_cyc%0d", i), 32'(wr_cyc[base+i] - s), 32'(i + 1));
    end
    check_eq("fill_busy_fall", 32'(f - s), 32'd6);
    check_eq("fill_no_irq", 32'(irq_n - ibase), 32'd0);

    // COPY with IRQ enabled and random grant stalls
    exp_src = '{16'h7A3C, 16'h7A3D, 16'h7A3E};
    hwi(16'd3, 16'h0042, 16'd0, 16'd0, s);
    acc_mode = 2;
    base  = wr_n;
    rbase = rd_n;
    ibase = irq_n;
    hwi(16'd1, 16'h2000, 16'd3, 16'h3000, s);
    wait_idle(500, f);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("copy_mem%0d", i), 32'(mem_rd(16'h3000 + 16'(i))), 32'(exp_src[i]));
    check_eq("copy_writes", 32'(wr_n - base), 32'd3);
    check_eq("copy_reads", 32'(rd_n - rbase), 32'd3);
    check_eq("copy_irq_cnt", 32'(irq_n - ibase), 32'd1);
    check_eq("copy_irq_msg", 32'(irq_last), 32'h0042);

    // FILL across the top of the address space
    acc_mode = 1;
    base = wr_n;
    hwi(16'd2, 16'h1234, 16'd4, 16'hFFFE, s);
    wait_idle(50, f);
    check_eq("wrap_count", 32'(wr_n - base), 32'd4);
    check_eq("wrap_a0", 32'(wr_addr[base+0]), 32'hFFFE);
    check_eq("wrap_a1", 32'(wr_addr[base+1]), 32'hFFFF);
    check_eq("wrap_a2", 32'(wr_addr[base+2]), 32'h0000);
    check_eq("wrap_a3", 32'(wr_addr[base+3]), 32'h0001);

    // Zero-length COPY with interrupts disabled
    hwi(16'd3, 16'h0000, 16'd0, 16'd0, s);
    wbase = want_n;
    bbase = busy_n;
    ibase = irq_n;
    hwi(16'd1, 16'h2000, 16'd0, 16'h3000, s);
    wait_idle(20, f);
    check_eq("len0_want", 32'(want_n - wbase), 32'd0);
    check_eq("len0_busy_cycles", 32'(busy_n - bbase), 32'd1);
    check_eq("len0_no_irq", 32'(irq_n - ibase), 32'd0);

    // STATUS mid-FILL, and a COPY strobed while busy must be ignored
    acc_mode = 1;
    base  = wr_n;
    rbase = rd_n;
    hwi(16'd2, 16'h7777, 16'd10, 16'h0500, s);
    wait_writes(base + 6, 50);
    acc_mode = 0;
    hwi(16'd0, 16'd0, 16'd0, 16'd0, s);
    check_eq("status_wren", 32'(c_wren), 32'd1);
    check_eq("status_remaining", 32'(c_out), 32'd4);
    @(negedge clk);
    check_eq("status_wren_pulse", 32'(c_wren), 32'd0);
    hwi(16'd1, 16'h6000, 16'd5, 16'h6800, s);
    acc_mode = 1;
    wait_idle(100, f);
    check_eq("busyfill_count", 32'(wr_n - base), 32'd10);
    for (int i = 0; i < 10 && base + i < wr_n; i++) begin
      check_eq($sformatf("busyfill_addr%0d", i), 32'(wr_addr[base+i]), 32'h0500 + 32'(i));
      check_eq($sformatf("busyfill_dat%0d", i), 32'(wr_dat[base+i]), 32'h7777);
    end
    check_eq("busyfill_no_reads", 32'(rd_n - rbase), 32'd0);

    // Reset in the middle of a COPY
    hwi(16'd3, 16'h0077, 16'd0, 16'd0, s);
    base = wr_n;
    hwi(16'd1, 16'h4000, 16'd8, 16'h4800, s);
    wait_writes(base + 3, 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_want", 32'(dma_bus.DMA_want), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_irqmsg", 32'(irq_msg), 32'd0);
    check_eq("midrst_first_dat", 32'(wr_dat[base]), 32'h1A3C);
    wbase = want_n;
    ibase = irq_n;
    repeat (40) @(negedge clk);
    check_eq("midrst_writes", 32'(wr_n - base), 32'd3);
    check_eq("midrst_no_want", 32'(want_n - wbase), 32'd0);
    check_eq("midrst_no_irq", 32'(irq_n - ibase), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
